// File: rtl/wl_dmem_arbiter.sv
// rtl/wl_dmem_arbiter.sv - core/bus arbiter for a single-port data memory
// Core has priority; a saturating stall counter bounds how long the bus can starve.
module wl_dmem_arbiter #(
  parameter int NumWords  = 256,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int MaxStall  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         c_req_i,
  input  logic [AddrWidth-1:0]         c_addr_i,
  input  logic                         c_we_i,
  input  logic [DataWidth-1:0]         c_wdata_i,
  input  logic [DataWidth/8-1:0]       c_be_i,
  input  logic                         b_req_i,
  input  logic [AddrWidth-1:0]         b_addr_i,
  input  logic                         b_we_i,
  input  logic [DataWidth-1:0]         b_wdata_i,
  input  logic [DataWidth/8-1:0]       b_be_i,
  output logic                         c_gnt_o,
  output logic                         b_gnt_o,
  output logic                         c_rvalid_o,
  output logic                         b_rvalid_o,
  output logic [DataWidth-1:0]         c_rdata_o,
  output logic [DataWidth-1:0]         b_rdata_o,
  output logic                         c_err_o,
  output logic                         b_err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(NumWords)-1:0]  mem_addr_o,
  output logic [DataWidth-1:0]         mem_wdata_o,
  output logic [DataWidth/8-1:0]       mem_be_o,
  input  logic [DataWidth-1:0]         mem_rdata_i
);

  localparam int WordAw = $clog2(NumWords);
  localparam int StallW = $clog2(MaxStall + 1);
  localparam logic [StallW-1:0]  StallMax   = StallW'(MaxStall);
  localparam logic [AddrWidth:0] RangeLimit = (AddrWidth + 1)'(NumWords * 4);

  logic                 w_b_win;
  logic                 w_c_win;
  logic                 w_grant;
  logic                 w_in_range;
  logic [AddrWidth-1:0] w_addr;
  logic [StallW-1:0]    r_stall;
  logic                 r_rsp_valid;
  logic                 r_rsp_sel;
  logic                 r_rsp_err;

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    w_b_win     = !rst_i && b_req_i && (!c_req_i || (r_stall >= StallMax));
    w_c_win     = !rst_i && c_req_i && !w_b_win;
    w_grant     = w_b_win || w_c_win;
    w_addr      = w_b_win ? b_addr_i : c_addr_i;
    w_in_range  = ({1'b0, w_addr} < RangeLimit);
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (w_b_win) begin
      mem_we_o    = b_we_i;
      mem_addr_o  = b_addr_i[WordAw+1:2];
      mem_wdata_o = b_wdata_i;
      mem_be_o    = b_be_i;
    end else if (w_c_win) begin
      mem_we_o    = c_we_i;
      mem_addr_o  = c_addr_i[WordAw+1:2];
      mem_wdata_o = c_wdata_i;
      mem_be_o    = c_be_i;
    end
    mem_req_o = w_grant && w_in_range;
  end

  assign c_gnt_o = w_c_win;
  assign b_gnt_o = w_b_win;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall <= '0;
    end else if (b_req_i && !w_b_win) begin
      if (r_stall != StallMax) r_stall <= r_stall + StallW'(1);
    end else begin
      r_stall <= '0;
    end
  end

  // Memory has one cycle of read latency, so the response owner is remembered for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sel   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_grant;
      r_rsp_sel   <= w_b_win;
      r_rsp_err   <= w_grant && !w_in_range;
    end
  end

  assign c_rvalid_o = r_rsp_valid && !r_rsp_sel;
  assign b_rvalid_o = r_rsp_valid && r_rsp_sel;
  assign c_err_o    = c_rvalid_o && r_rsp_err;
  assign b_err_o    = b_rvalid_o && r_rsp_err;
  assign c_rdata_o  = (c_rvalid_o && !r_rsp_err) ? mem_rdata_i : '0;
  assign b_rdata_o  = (b_rvalid_o && !r_rsp_err) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_wl_dmem_arbiter.sv
// tb/tb_wl_dmem_arbiter.sv - self-checking bench for wl_dmem_arbiter
// Table-driven single-cycle vectors plus hand-written contention and reset sequences.
module tb_wl_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req, c_we, b_req, b_we;
  logic [31:0] c_addr, c_wdata, b_addr, b_wdata;
  logic [3:0]  c_be, b_be;
  logic        c_gnt, b_gnt, c_rvalid, b_rvalid, c_err, b_err;
  logic [31:0] c_rdata, b_rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] mem [256];
  int          wr_count = 0;
  int          n_total  = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  wl_dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .c_req_i(c_req), .c_addr_i(c_addr), .c_we_i(c_we), .c_wdata_i(c_wdata), .c_be_i(c_be),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_we_i(b_we), .b_wdata_i(b_wdata), .b_be_i(b_be),
    .c_gnt_o(c_gnt), .b_gnt_o(b_gnt), .c_rvalid_o(c_rvalid), .b_rvalid_o(b_rvalid),
    .c_rdata_o(c_rdata), .b_rdata_o(b_rdata), .c_err_o(c_err), .b_err_o(b_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  // SRAM model: one-cycle read latency, byte-masked writes, writes return 0.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        mem_rdata <= 32'h0;
        wr_count  <= wr_count + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        e_cg, e_bg, e_mreq, e_mwe;
    logic [7:0]  e_maddr;
    logic [3:0]  e_mbe;
    logic        e_crv, e_cerr;
    logic [31:0] e_crd;
    logic        e_brv, e_berr;
    logic [31:0] e_brd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd, input logic [3:0] cb,
    input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd, input logic [3:0] bb,
    input logic cg, input logic bg, input logic mr, input logic mw, input logic [7:0] ma, input logic [3:0] mb,
    input logic crv, input logic cer, input logic [31:0] crd,
    input logic brv, input logic ber, input logic [31:0] brd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd; v.c_be = cb;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_be = bb;
    v.e_cg = cg; v.e_bg = bg; v.e_mreq = mr; v.e_mwe = mw; v.e_maddr = ma; v.e_mbe = mb;
    v.e_crv = crv; v.e_cerr = cer; v.e_crd = crd;
    v.e_brv = brv; v.e_berr = ber; v.e_brd = brd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata; c_be = v.c_be;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata; b_be = v.b_be;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
  endtask

  initial begin
    idle_inputs();
    //           c: req we addr wdata be         b: req we addr wdata be           cg bg mr mw ma mbe     crv cer crd          brv ber brd
    vecs.push_back(mk(1,1,32'h10,32'hDEADBEEF,4'hF, 0,0,0,0,0,                   1,0,1,1,8'd4,4'hF, 0,0,32'h0,         0,0,32'h0));
    vecs.push_back(mk(1,0,32'h10,0,4'hF,            0,0,0,0,0,                   1,0,1,0,8'd4,4'hF, 1,0,32'h0,         0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    0,0,0,0,0,                   0,0,0,0,8'd0,4'h0, 1,0,32'hDEADBEEF,  0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    1,1,32'h0,32'hAAAAAAAA,4'hF, 0,1,1,1,8'd0,4'hF, 0,0,32'h0,         0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    1,1,32'h0,32'h11223344,4'h3, 0,1,1,1,8'd0,4'h3, 0,0,32'h0,         1,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    1,0,32'h0,0,4'hF,            0,1,1,0,8'd0,4'hF, 0,0,32'h0,         1,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    0,0,0,0,0,                   0,0,0,0,8'd0,4'h0, 0,0,32'h0,         1,0,32'hAAAA3344));
    vecs.push_back(mk(1,0,32'h400,0,4'hF,           0,0,0,0,0,                   1,0,0,0,8'd0,4'hF, 0,0,32'h0,         0,0,32'h0));
    vecs.push_back(mk(1,1,32'h400,32'h55555555,4'hF,0,0,0,0,0,                   1,0,0,1,8'd0,4'hF, 1,1,32'h0,         0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    0,0,0,0,0,                   0,0,0,0,8'd0,4'h0, 1,1,32'h0,         0,0,32'h0));
    vecs.push_back(mk(1,0,32'h10,0,4'hF,            0,0,0,0,0,                   1,0,1,0,8'd4,4'hF, 0,0,32'h0,         0,0,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,4'hF,             0,0,0,0,0,                   1,0,1,0,8'd0,4'hF, 1,0,32'hDEADBEEF,  0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    1,0,32'h10,0,4'hF,           0,1,1,0,8'd4,4'hF, 1,0,32'hAAAA3344,  0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,                    0,0,0,0,0,                   0,0,0,0,8'd0,4'h0, 0,0,32'h0,         1,0,32'hDEADBEEF));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst c_gnt", {31'b0, c_gnt}, 0);
    chk("rst c_rvalid", {31'b0, c_rvalid}, 0);
    chk("rst b_rvalid", {31'b0, b_rvalid}, 0);
    chk("rst mem_req", {31'b0, mem_req}, 0);
    chk("rst stall", 32'(dut.r_stall), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d c_gnt", i),    {31'b0, c_gnt},    {31'b0, vecs[i].e_cg});
      chk($sformatf("v%0d b_gnt", i),    {31'b0, b_gnt},    {31'b0, vecs[i].e_bg});
      chk($sformatf("v%0d mem_req", i),  {31'b0, mem_req},  {31'b0, vecs[i].e_mreq});
      chk($sformatf("v%0d mem_we", i),   {31'b0, mem_we},   {31'b0, vecs[i].e_mwe});
      chk($sformatf("v%0d mem_addr", i), {24'b0, mem_addr}, {24'b0, vecs[i].e_maddr});
      chk($sformatf("v%0d mem_be", i),   {28'b0, mem_be},   {28'b0, vecs[i].e_mbe});
      chk($sformatf("v%0d c_rvalid", i), {31'b0, c_rvalid}, {31'b0, vecs[i].e_crv});
      chk($sformatf("v%0d c_err", i),    {31'b0, c_err},    {31'b0, vecs[i].e_cerr});
      chk($sformatf("v%0d c_rdata", i),  c_rdata,           vecs[i].e_crd);
      chk($sformatf("v%0d b_rvalid", i), {31'b0, b_rvalid}, {31'b0, vecs[i].e_brv});
      chk($sformatf("v%0d b_err", i),    {31'b0, b_err},    {31'b0, vecs[i].e_berr});
      chk($sformatf("v%0d b_rdata", i),  b_rdata,           vecs[i].e_brd);
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("oor write dropped wr_count", 32'(wr_count), 3);

    // Contention: core reads word 0, bus reads word 4, both held for 10 cycles.
    c_req = 1; c_addr = 32'h0; c_be = 4'hF;
    b_req = 1; b_addr = 32'h10; b_be = 4'hF;
    begin
      logic prev_b;
      prev_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
        logic exp_b;
        exp_b = (i % 5 == 4);
        @(negedge clk);
        chk($sformatf("ct%0d b_gnt", i), {31'b0, b_gnt}, {31'b0, exp_b});
        chk($sformatf("ct%0d c_gnt", i), {31'b0, c_gnt}, {31'b0, !exp_b});
        chk($sformatf("ct%0d stall", i), 32'(dut.r_stall), 32'(i % 5));
        if (i > 0) begin
          chk($sformatf("ct%0d c_rvalid", i), {31'b0, c_rvalid}, {31'b0, !prev_b});
          chk($sformatf("ct%0d b_rvalid", i), {31'b0, b_rvalid}, {31'b0, prev_b});
          chk($sformatf("ct%0d rdata", i), prev_b ? b_rdata : c_rdata,
              prev_b ? 32'hDEADBEEF : 32'hAAAA3344);
        end
        prev_b = exp_b;
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    @(negedge clk);
    chk("ct tail b_rvalid", {31'b0, b_rvalid}, 1);
    chk("ct tail c_rvalid", {31'b0, c_rvalid}, 0);
    @(posedge clk); #1;

    // Reset mid-flight: a pending core response and a nonzero stall count are wiped.
    c_req = 1; c_addr = 32'h10; c_be = 4'hF;
    b_req = 1; b_addr = 32'h0;  b_be = 4'hF;
    @(negedge clk);
    chk("mf c_gnt", {31'b0, c_gnt}, 1);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("mf pre c_rvalid", {31'b0, c_rvalid}, 1);
    chk("mf pre stall", 32'(dut.r_stall), 1);
    rst = 1'b1;
    #1;
    chk("mf c_rvalid", {31'b0, c_rvalid}, 0);
    chk("mf stall", 32'(dut.r_stall), 0);
    b_req = 1; b_addr = 32'h10; b_be = 4'hF;
    #1;
    chk("mf b_gnt in rst", {31'b0, b_gnt}, 0);
    chk("mf mem_req in rst", {31'b0, mem_req}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mf b_gnt after", {31'b0, b_gnt}, 1);
    chk("mf mem_addr after", {24'b0, mem_addr}, 4);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("mf b_rvalid", {31'b0, b_rvalid}, 1);
    chk("mf b_rdata", b_rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wl_dmem_arbiter.md
# wl_dmem_arbiter

Arbitrates a single-port core data memory between two requesters: the Snitch core LSU (port `c`) and the cluster bus (port `b`), both using an SRAM-style req/gnt/rvalid protocol. The core has priority. A stall counter guarantees the bus a grant after a bounded number of lost cycles. The block maps byte offsets to word indices, blocks out-of-range accesses, and routes each one-cycle-latency response back to the port that issued the request.

## Interface

Parameters:
- `NumWords`, default 256: data memory depth in words. Must be ≥ 2 and a power of two.
- `DataWidth`, default 32: word width. Byte enable width is `DataWidth/8`.
- `AddrWidth`, default 32: requester byte-offset width, relative to `DataMemBaseAddr`.
- `MaxStall`, default 4: consecutive lost bus cycles before the bus is forced to win. Must be ≥ 1.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `c_req_i`, `b_req_i`  in  1  request valid, one per port.
- `c_addr_i`, `b_addr_i`  in  AddrWidth  byte offset.
- `c_we_i`, `b_we_i`  in  1  1 = write, 0 = read.
- `c_wdata_i`, `b_wdata_i`  in  DataWidth  write data.
- `c_be_i`, `b_be_i`  in  DataWidth/8  byte enables.
- `c_gnt_o`, `b_gnt_o`  out  1  request accepted this cycle.
- `c_rvalid_o`, `b_rvalid_o`  out  1  response valid.
- `c_rdata_o`, `b_rdata_o`  out  DataWidth  read data.
- `c_err_o`, `b_err_o`  out  1  out-of-range flag; valid only with `rvalid`.
- `mem_req_o`  out  1  memory access strobe.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  $clog2(NumWords)  word index.
- `mem_wdata_o`  out  DataWidth  memory write data.
- `mem_be_o`  out  DataWidth/8  memory byte enables.
- `mem_rdata_i`  in  DataWidth  memory read data; valid one cycle after `mem_req_o`.

## Operation

- Arbitration is combinational in the same cycle. At most one grant per cycle.
  - Bus wins (`b_gnt_o=1`) if `b_req_i && (!c_req_i || stall_q >= MaxStall)`.
  - Otherwise the core wins if `c_req_i`.
- Stall counter `stall_q`, width $clog2(MaxStall+1), reset 0:
  - Increments, saturating at MaxStall, when `b_req_i && !b_gnt_o`.
  - Clears to 0 when `b_gnt_o` is high or `b_req_i` is low.
- Address mapping:
  - Word index = addr[$clog2(NumWords)+1:2]. Bits [1:0] are ignored.
  - In range means addr < NumWords*4.
- Memory strobe: `mem_req_o = winner_granted && in_range`.
  - `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are muxed from the winning port.
  - With no winner, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are 0.
- Out-of-range request:
  - Still granted.
  - No memory access (`mem_req_o=0`), so out-of-range writes are dropped.
  - Response has rdata = 0 and err = 1.
- Response tracking registers, all reset 0:
  - `rsp_valid_q`: set to 1 on any grant, cleared otherwise.
  - `rsp_sel_q`: 0 = core, 1 = bus.
  - `rsp_err_q`: captured out-of-range flag.
- Response outputs:
  - `X_rvalid_o = rsp_valid_q && (rsp_sel_q == X)`.
  - `X_rdata_o = mem_rdata_i` when valid and not err; 0 otherwise.
  - `X_err_o = rsp_err_q` when valid; 0 otherwise.
- Writes also produce a response (rvalid, rdata = 0) as a write acknowledge.
- No outstanding-request limit beyond one per cycle. Requesters may issue back-to-back.

## Timing

- Reset values: every output is 0. `stall_q`, `rsp_valid_q`, `rsp_sel_q` and `rsp_err_q` are 0.
- Request protocol:
  - The requester holds req/addr/we/wdata/be stable until it sees gnt.
  - gnt depends combinationally on req, with no combinational path from gnt back to req.
- Latency: grant in cycle N gives rvalid in cycle N+1, for reads, writes and errors alike.
  - Full throughput is one grant per cycle.
- Simultaneous requests with `stall_q < MaxStall`: the core wins and `stall_q` increments.
  - With both ports requesting continuously, the bus wins every (MaxStall+1)-th cycle.
  - The bus grant cycle clears `stall_q` to 0.
- A response in N+1 and a new grant in N+1 coexist. The new response appears in N+2.
- Reset asserted mid-transaction:
  - All registers clear asynchronously and any pending rvalid is lost.
  - Outputs are 0 while `rst_i` is high.
  - The first grant is possible in the first cycle after deassertion.

## Test plan

- Core-only read:
  - Stimulus: write 0xDEADBEEF at offset 0x10 with be = 0xF. Then `c_req_i`, `c_addr_i = 0x10`, `c_we_i = 0`.
  - Required: `c_gnt_o` same cycle, `mem_addr_o = 4`, then `c_rvalid_o` with rdata 0xDEADBEEF one cycle later, `b_rvalid_o = 0`.
- Contention with MaxStall = 4:
  - Stimulus: both ports request continuously for 10 cycles.
  - Required grants: C,C,C,C,B,C,C,C,C,B. `stall_q` sequence 0,1,2,3,4,0,1,2,3,4.
  - Required: each rvalid lands on the port granted one cycle earlier.
- Byte-enable write:
  - Stimulus: bus writes 0x11223344 with be = 0b0011 to offset 0x0 holding 0xAAAAAAAA, then reads it back.
  - Required: `mem_be_o = 0b0011`, readback 0xAAAA3344.
- Out of range, NumWords = 256:
  - Stimulus: core read at 0x400.
  - Required: `c_gnt_o = 1`, `mem_req_o = 0`, next cycle `c_rvalid_o = 1`, `c_err_o = 1`, rdata 0.
  - Stimulus: core write at 0x400.
  - Required: no memory write occurs.
- Back-to-back alternation:
  - Stimulus: core reads at cycles 0, 1; bus reads at cycle 2.
  - Required: rvalid on c at cycles 1, 2 and on b at cycle 3, with no dropped responses.
- Reset mid-flight:
  - Stimulus: assert `rst_i` asynchronously one cycle after a core grant.
  - Required: `c_rvalid_o` forced to 0 immediately, `stall_q = 0`.
  - After deassertion, a new bus request is granted in the first cycle.
